// File: rtl/fir_filter_pkg.sv
// ============================================================================
// fir_filter_pkg : widths, types and fixed coefficient set of the 16-tap FIR
// Revision: 1.0
// ============================================================================
`default_nettype none

package fir_filter_pkg;

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int NTAPS  = 16;
  localparam int OUT_W  = 33;
  localparam int ACC_W  = 36;
  localparam int PROD_W = DATA_W + COEF_W;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic signed [OUT_W-1:0]  out_t;

  // Symmetric low-pass taps; sum|h| stays below 2^17 so the 33-bit output never wraps.
  localparam coef_t COEFS [NTAPS] = '{
    -16'sd120, -16'sd310, -16'sd250,  16'sd580,
     16'sd2100, 16'sd4600, 16'sd7300, 16'sd9100,
     16'sd9100, 16'sd7300, 16'sd4600, 16'sd2100,
     16'sd580, -16'sd250, -16'sd310, -16'sd120
  };

endpackage : fir_filter_pkg

`default_nettype wire

// File: rtl/fir_mac_tree.sv
// ============================================================================
// fir_mac_tree : sums the registered tap products into a registered 36-bit total
// Revision: 1.0
// ============================================================================
`default_nettype none

module fir_mac_tree
  import fir_filter_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_en,
  input  prod_t i_prod [NTAPS],
  output acc_t  o_sum
);

  acc_t w_sum;
  acc_t r_sum;

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < NTAPS; k++) begin
      w_sum = w_sum + acc_t'(i_prod[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum <= '0;
    end else if (i_en) begin
      r_sum <= w_sum;
    end
  end

  assign o_sum = r_sum;

endmodule : fir_mac_tree

`default_nettype wire

// File: rtl/fir_filter.sv
// ============================================================================
// fir_filter : streaming 16-tap direct-form FIR, 2 pipeline stages after the delay line
// Revision: 1.0
// ============================================================================
`default_nettype none

module fir_filter
  import fir_filter_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] FilterIn,
  input  logic                     ValidIn,
  output logic signed [OUT_W-1:0]  data_out,
  output logic                     ValidOut
);

  sample_t r_x    [NTAPS];
  prod_t   w_prod [NTAPS];
  prod_t   r_prod [NTAPS];
  logic    r_v_dl;
  logic    r_v_prod;
  logic    r_v_out;
  acc_t    w_acc;

  // Delay line and valid pipeline; the delay line only advances on accepted samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NTAPS; k++) begin
        r_x[k] <= '0;
      end
      r_v_dl   <= 1'b0;
      r_v_prod <= 1'b0;
      r_v_out  <= 1'b0;
    end else begin
      r_v_dl   <= ValidIn;
      r_v_prod <= r_v_dl;
      r_v_out  <= r_v_prod;
      if (ValidIn) begin
        r_x[0] <= FilterIn;
        for (int k = 1; k < NTAPS; k++) begin
          r_x[k] <= r_x[k-1];
        end
      end
    end
  end

  for (genvar gk = 0; gk < NTAPS; gk++) begin : g_prod
    assign w_prod[gk] = prod_t'(r_x[gk]) * prod_t'(COEFS[gk]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NTAPS; k++) begin
        r_prod[k] <= '0;
      end
    end else if (r_v_dl) begin
      for (int k = 0; k < NTAPS; k++) begin
        r_prod[k] <= w_prod[k];
      end
    end
  end

  fir_mac_tree u_mac_tree (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (r_v_prod),
    .i_prod (r_prod),
    .o_sum  (w_acc)
  );

  assign data_out = out_t'(w_acc);
  assign ValidOut = r_v_out;

endmodule : fir_filter

`default_nettype wire

// File: tb/tb_fir_filter.sv
// ============================================================================
// tb_fir_filter : randomized and directed checks of fir_filter against a convolution model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fir_filter;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               ValidIn;
  logic signed [15:0] FilterIn;
  logic signed [32:0] data_out;
  logic               ValidOut;

  int cmp  = 0;
  int errs = 0;

  longint h [16] = '{-120, -310, -250, 580, 2100, 4600, 7300, 9100,
                     9100, 7300, 4600, 2100, 580, -250, -310, -120};

  // Reference: y = sum h[k]*x[n-k] over accepted samples, result visible two edges later.
  longint             hist [$];
  logic               pv0, pv1;
  longint             pd0, pd1;
  logic               exp_v;
  logic signed [32:0] exp_d;

  always #5 clk = ~clk;

  fir_filter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .FilterIn (FilterIn),
    .ValidIn  (ValidIn),
    .data_out (data_out),
    .ValidOut (ValidOut)
  );

  task automatic drive(input logic rn, input logic v, input logic signed [15:0] d);
    longint y;
    rst_n = rn; ValidIn = v; FilterIn = d;
    @(posedge clk); #1;
    if (!rn) begin
      hist.delete();
      pv0 = 1'b0; pv1 = 1'b0; pd0 = 0; pd1 = 0;
      exp_v = 1'b0; exp_d = '0;
    end else begin
      exp_v = pv1;
      if (pv1) exp_d = 33'(pd1);
      pv1 = pv0; pd1 = pd0; pv0 = v;
      if (v) begin
        hist.push_front(longint'(d));
        if (hist.size() > 16) void'(hist.pop_back());
        y = 0;
        foreach (hist[k]) y += h[k] * hist[k];
        pd0 = y;
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 16'($urandom));
      cmp++;
      if (ValidOut !== 1'b0 || data_out !== 33'sd0) begin
        errs++;
        $display("FAIL reset_hold: got valid=%b data=%0d want valid=0 data=0", ValidOut, data_out);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 16'($urandom));
      cmp++;
      if (ValidOut !== 1'b0 || data_out !== 33'sd0) begin
        errs++;
        $display("FAIL reset_release: got valid=%b data=%0d want valid=0 data=0", ValidOut, data_out);
      end
    end
  endtask

  task automatic test_impulse();
    logic signed [32:0] want;
    drive(1'b0, 1'b0, 16'sd0);
    for (int i = 0; i < 18; i++) begin
      drive(1'b1, i < 16, (i == 0) ? 16'sd1 : 16'sd0);
      cmp++;
      if (ValidOut !== (i >= 2)) begin
        errs++;
        $display("FAIL impulse_valid[%0d]: got %b want %b", i, ValidOut, (i >= 2));
      end
      if (i >= 2) begin
        want = 33'(h[i-2]);
        cmp++;
        if (data_out !== want) begin
          errs++;
          $display("FAIL impulse_data[%0d]: got %0d want %0d", i, data_out, want);
        end
      end
    end
  endtask

  task automatic test_step();
    longint part = 0;
    drive(1'b0, 1'b0, 16'sd0);
    for (int i = 0; i < 22; i++) begin
      drive(1'b1, i < 20, 16'sd1000);
      if (i >= 2) begin
        if (i - 2 < 16) part += 1000 * h[i-2];
        cmp++;
        if (ValidOut !== 1'b1 || data_out !== 33'(part)) begin
          errs++;
          $display("FAIL step[%0d]: got valid=%b data=%0d want valid=1 data=%0d", i, ValidOut, data_out, part);
        end
      end
    end
    cmp++;
    if (data_out !== 33'sd46000000) begin
      errs++;
      $display("FAIL step_dc: got %0d want 46000000", data_out);
    end
  endtask

  task automatic test_extremes();
    drive(1'b0, 1'b0, 16'sd0);
    for (int i = 0; i < 18; i++) begin
      drive(1'b1, i < 16, -16'sd32768);
    end
    cmp++;
    if (ValidOut !== 1'b1 || data_out !== -33'sd1507328000) begin
      errs++;
      $display("FAIL extreme_neg: got valid=%b data=%0d want valid=1 data=-1507328000", ValidOut, data_out);
    end
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 1'b1, i[0] ? -16'sd32768 : 16'sd32767);
      cmp++;
      if (ValidOut !== exp_v || data_out !== exp_d) begin
        errs++;
        $display("FAIL extreme_alt[%0d]: got valid=%b data=%0d want valid=%b data=%0d", i, ValidOut, data_out, exp_v, exp_d);
      end
    end
  endtask

  task automatic test_gaps();
    logic               v [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic signed [15:0] d [8] = '{16'sd5, 16'sd99, 16'sd7, -16'sd99, 16'sd9, 16'sd3, 16'sd3, 16'sd3};
    logic signed [32:0] want [3] = '{-33'sd600, -33'sd2390, -33'sd4500};
    int pulses = 0;
    drive(1'b0, 1'b0, 16'sd0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, v[i], d[i]);
      cmp++;
      if (ValidOut !== (i >= 2 && v[i-2])) begin
        errs++;
        $display("FAIL gaps_valid[%0d]: got %b want %b", i, ValidOut, (i >= 2 && v[i-2]));
      end
      if (ValidOut === 1'b1) begin
        if (pulses < 3) begin
          cmp++;
          if (data_out !== want[pulses]) begin
            errs++;
            $display("FAIL gaps_data[%0d]: got %0d want %0d", pulses, data_out, want[pulses]);
          end
        end
        pulses++;
      end else if (i >= 3) begin
        cmp++;
        if (data_out !== exp_d) begin
          errs++;
          $display("FAIL gaps_hold[%0d]: got %0d want %0d", i, data_out, exp_d);
        end
      end
    end
    cmp++;
    if (pulses != 3) begin
      errs++;
      $display("FAIL gaps_count: got %0d want 3", pulses);
    end
  endtask

  task automatic test_random();
    logic v;
    for (int i = 0; i < 120; i++) begin
      v = ($urandom_range(0, 3) != 0);
      drive(1'b1, v, 16'($urandom));
      cmp++;
      if (ValidOut !== exp_v || data_out !== exp_d) begin
        errs++;
        $display("FAIL random[%0d]: got valid=%b data=%0d want valid=%b data=%0d", i, ValidOut, data_out, exp_v, exp_d);
      end
    end
  endtask

  task automatic test_midreset();
    logic signed [32:0] want;
    drive(1'b0, 1'b0, 16'sd0);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, (i == 0) ? 16'sd1 : 16'sd0);
    drive(1'b0, 1'b1, 16'($urandom));
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 16'sd0);
      cmp++;
      if (ValidOut !== 1'b0 || data_out !== 33'sd0) begin
        errs++;
        $display("FAIL midreset_flush[%0d]: got valid=%b data=%0d want valid=0 data=0", i, ValidOut, data_out);
      end
    end
    for (int i = 0; i < 18; i++) begin
      drive(1'b1, i < 16, (i == 0) ? 16'sd1 : 16'sd0);
      if (i >= 2) begin
        want = 33'(h[i-2]);
        cmp++;
        if (ValidOut !== 1'b1 || data_out !== want) begin
          errs++;
          $display("FAIL midreset_impulse[%0d]: got valid=%b data=%0d want valid=1 data=%0d", i, ValidOut, data_out, want);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; ValidIn = 1'b0; FilterIn = '0;
    test_reset();
    test_impulse();
    test_step();
    test_extremes();
    test_gaps();
    test_random();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule : tb_fir_filter

`default_nettype wire
